// File: rtl/tick_scheduler.sv
// Per-channel periodic event scheduler driven by a shared base tick.
// Expired channels are presented one at a time through a round-robin arbiter.
module tick_scheduler #(
    parameter int CH = 4,
    parameter int PW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tick,
    input  logic                   i_cfg_wr,
    input  logic [$clog2(CH)-1:0]  i_cfg_ch,
    input  logic [PW-1:0]          i_cfg_period,
    input  logic                   i_cfg_en,
    output logic                   o_valid,
    output logic [$clog2(CH)-1:0]  o_ch,
    input  logic                   i_ready,
    output logic [CH-1:0]          o_overrun
);

    localparam int CW = $clog2(CH);

    logic [CH-1:0] en;
    logic [CH-1:0] pend;
    logic [CH-1:0] ovr;
    logic [CH-1:0] wr_hit;
    logic [CH-1:0] exp_hit;
    logic [CH-1:0] gnt;
    logic [PW-1:0] per [CH];
    logic [PW-1:0] cnt [CH];
    logic [CW-1:0] last_grant;
    logic [CW-1:0] gnt_idx;
    logic          gnt_any;
    logic          slot_free;
    int            idx;

    assign slot_free = !o_valid || i_ready;
    assign o_overrun = ovr;

    always_comb begin
        wr_hit  = '0;
        exp_hit = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i]  = i_cfg_wr && (i_cfg_ch == CW'(i));
            exp_hit[i] = i_tick && en[i] && (per[i] != '0)
                         && (cnt[i] == PW'(1));
        end
    end

    // Round-robin search starts just after the last granted channel.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = 0;
        for (int k = 1; k <= CH; k++) begin
            idx = (int'(last_grant) + k) % CH;
            if (!gnt_any && pend[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
        if (slot_free && gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            en   <= '0;
            pend <= '0;
            ovr  <= '0;
            for (int i = 0; i < CH; i++) begin
                per[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (wr_hit[i]) begin
                    en[i]   <= i_cfg_en;
                    per[i]  <= i_cfg_period;
                    cnt[i]  <= i_cfg_period;
                    pend[i] <= 1'b0;
                    ovr[i]  <= 1'b0;
                end else begin
                    if (i_tick && en[i] && (per[i] != '0)) begin
                        cnt[i] <= exp_hit[i] ? per[i] : cnt[i] - 1'b1;
                    end
                    // A grant and a new expiry together leave pending set.
                    if (exp_hit[i]) begin
                        pend[i] <= 1'b1;
                        if (pend[i] && !gnt[i]) begin
                            ovr[i] <= 1'b1;
                        end
                    end else if (gnt[i]) begin
                        pend[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_ch       <= '0;
            last_grant <= CW'(CH - 1);
        end else if (slot_free) begin
            o_valid <= gnt_any;
            if (gnt_any) begin
                o_ch       <= gnt_idx;
                last_grant <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler: directed scenarios plus a random phase,
// all checked against an elapsed-tick reference model.
module tb_tick_scheduler;

    localparam int CH = 4;
    localparam int PW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_tick = 1'b0;
    logic          i_cfg_wr = 1'b0;
    logic [1:0]    i_cfg_ch = '0;
    logic [PW-1:0] i_cfg_period = '0;
    logic          i_cfg_en = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [1:0]    o_ch;
    logic [CH-1:0] o_overrun;

    tick_scheduler #(.CH(CH), .PW(PW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .i_cfg_wr     (i_cfg_wr),
        .i_cfg_ch     (i_cfg_ch),
        .i_cfg_period (i_cfg_period),
        .i_cfg_en     (i_cfg_en),
        .o_valid      (o_valid),
        .o_ch         (o_ch),
        .i_ready      (i_ready),
        .o_overrun    (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    // Reference model: ticks elapsed since configuration, not a down-counter.
    bit            m_en   [CH];
    int            m_per  [CH];
    int            m_ticks[CH];
    bit            m_pend [CH];
    logic [CH-1:0] m_ovr;
    bit            m_valid;
    int            m_ch;
    int            m_last;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_en[i] = 0;
            m_per[i] = 0;
            m_ticks[i] = 0;
            m_pend[i] = 0;
        end
        m_ovr = '0;
        m_valid = 0;
        m_ch = 0;
        m_last = CH - 1;
    endtask

    task automatic model_step();
        bit free;
        bit anyp;
        int g;
        bit ex;
        bit [CH-1:0] gv;
        free = !m_valid || i_ready;
        anyp = 0;
        g = 0;
        gv = '0;
        if (free) begin
            for (int k = 1; k <= CH; k++) begin
                int j;
                j = (m_last + k) % CH;
                if (!anyp && m_pend[j]) begin
                    anyp = 1;
                    g = j;
                end
            end
        end
        if (anyp) gv[g] = 1'b1;
        for (int i = 0; i < CH; i++) begin
            if (i_cfg_wr && int'(i_cfg_ch) == i) begin
                m_en[i] = i_cfg_en;
                m_per[i] = int'(i_cfg_period);
                m_ticks[i] = 0;
                m_pend[i] = 0;
                m_ovr[i] = 1'b0;
            end else begin
                ex = 0;
                if (i_tick && m_en[i] && m_per[i] != 0) begin
                    m_ticks[i]++;
                    ex = (m_ticks[i] % m_per[i] == 0);
                end
                if (ex) begin
                    if (m_pend[i] && !gv[i]) m_ovr[i] = 1'b1;
                    m_pend[i] = 1;
                end else if (gv[i]) begin
                    m_pend[i] = 0;
                end
            end
        end
        if (free) begin
            m_valid = anyp;
            if (anyp) begin
                m_ch = g;
                m_last = g;
            end
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        chk("valid", o_valid, m_valid);
        if (m_valid) chk("ch", o_ch, m_ch);
        chk("overrun", o_overrun, m_ovr);
        i_tick = 1'b0;
        i_cfg_wr = 1'b0;
    endtask

    task automatic cfg(input int ch, input int per, input bit en);
        i_cfg_wr = 1'b1;
        i_cfg_ch = 2'(ch);
        i_cfg_period = PW'(per);
        i_cfg_en = en;
        cyc();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_tick = 1'b0;
        i_cfg_wr = 1'b0;
        #1;
        model_reset();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("rst_valid", o_valid, 0);
        chk("rst_ch", o_ch, 0);
        chk("rst_ovr", o_overrun, 0);
    endtask

    initial begin
        bit seen;
        model_reset();

        // Periodic firing of one channel.
        do_reset();
        i_ready = 1'b1;
        cfg(0, 3, 1);
        for (int t = 1; t <= 9; t++) begin
            i_tick = 1'b1;
            cyc();
            cyc();
            chk("r31_valid", o_valid, (t % 3 == 0));
            if (t % 3 == 0) chk("r31_ch", o_ch, 0);
            repeat (8) cyc();
        end
        chk("r31_ovr", o_overrun, 0);

        // Round-robin rotation over simultaneous expiries.
        do_reset();
        i_ready = 1'b1;
        for (int c = 0; c < CH; c++) cfg(c, 1, 1);
        i_tick = 1'b1;
        cyc();
        for (int k = 0; k < CH; k++) begin
            cyc();
            chk("r32_valid", o_valid, 1);
            chk("r32_ch", o_ch, k);
        end
        i_tick = 1'b1;
        cyc();
        chk("r32_idle", o_valid, 0);
        cyc();
        chk("r32_wrap", o_ch, 0);
        repeat (4) cyc();

        // Overrun under backpressure, cleared by configuration.
        do_reset();
        i_ready = 1'b0;
        cfg(1, 1, 1);
        i_tick = 1'b1;
        cyc();
        cyc();
        i_tick = 1'b1;
        cyc();
        i_tick = 1'b1;
        cyc();
        chk("r33_ovr", o_overrun, 4'b0010);
        chk("r33_valid", o_valid, 1);
        chk("r33_ch", o_ch, 1);
        cfg(1, 1, 1);
        chk("r33_clr", o_overrun, 0);
        chk("r33_hold", o_valid, 1);
        i_ready = 1'b1;
        repeat (3) cyc();

        // Configuration write beats a same-cycle expiry.
        do_reset();
        i_ready = 1'b1;
        cfg(2, 2, 1);
        i_tick = 1'b1;
        cyc();
        i_tick = 1'b1;
        cfg(2, 2, 1);
        cyc();
        chk("r34_none", o_valid, 0);
        i_tick = 1'b1;
        cyc();
        cyc();
        chk("r34_none2", o_valid, 0);
        i_tick = 1'b1;
        cyc();
        cyc();
        chk("r34_fire", o_valid, 1);
        chk("r34_ch", o_ch, 2);

        // Zero period and disabled channel never fire.
        do_reset();
        i_ready = 1'b1;
        cfg(0, 0, 1);
        cfg(3, 5, 0);
        seen = 0;
        for (int t = 0; t < 20; t++) begin
            i_tick = 1'b1;
            cyc();
            if (o_valid) seen = 1;
            cyc();
            if (o_valid) seen = 1;
        end
        chk("r35_never", seen, 0);

        // Asynchronous reset during a stalled transfer.
        do_reset();
        i_ready = 1'b0;
        cfg(1, 1, 1);
        i_tick = 1'b1;
        cyc();
        cyc();
        chk("r36_pre", o_valid, 1);
        i_rst = 1'b1;
        #1;
        chk("r36_valid", o_valid, 0);
        chk("r36_ch", o_ch, 0);
        chk("r36_ovr", o_overrun, 0);
        model_reset();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            i_tick = 1'b1;
            cyc();
            cyc();
        end
        chk("r36_quiet", o_valid, 0);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            i_tick = ($urandom_range(0, 2) == 0);
            i_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) begin
                i_cfg_wr = 1'b1;
                i_cfg_ch = 2'($urandom_range(0, CH - 1));
                i_cfg_period = PW'($urandom_range(0, 5));
                i_cfg_en = ($urandom_range(0, 4) != 0);
            end
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
